// File: rtl/sigmoid_pkg.sv
// Shared constants and types for the piecewise-linear sigmoid stream.
// All breakpoints/offsets are derived from FRAC so the datapath scales with
// the fixed-point format. Optional tanh mode: define SIGMOID_TANH_EN.
package sigmoid_pkg;

  typedef enum logic [1:0] {SEG_LIN0, SEG_LIN1, SEG_LIN2, SEG_SAT} seg_t;

  localparam int STAGES = 3;

  // 1.0
  function automatic int one_fx(input int frac);
    return 1 << frac;
  endfunction

  // Breakpoint 5.0: saturation
  function automatic int brk_sat(input int frac);
    return 5 << frac;
  endfunction

  // Breakpoint 2.375 = 19/8
  function automatic int brk_lin2(input int frac);
    return 19 << (frac - 3);
  endfunction

  // Breakpoint 1.0
  function automatic int brk_lin1(input int frac);
    return 1 << frac;
  endfunction

  // Offset 0.84375 = 27/32 (needs FRAC >= 5)
  function automatic int ofs_lin2(input int frac);
    return 27 << (frac - 5);
  endfunction

  // Offset 0.625 = 5/8
  function automatic int ofs_lin1(input int frac);
    return 5 << (frac - 3);
  endfunction

  // Offset 0.5
  function automatic int ofs_lin0(input int frac);
    return 1 << (frac - 1);
  endfunction

endpackage

// File: rtl/sigmoid_lane.sv
// One lane of the sigmoid datapath: S1 |x| + segment, S2 shift-add,
// S3 reflection/clamp + output register. Enables come from shared control.
// With SIGMOID_TANH_EN, a mode bit selects 2*sigma(2x)-1.
module sigmoid_lane
  import sigmoid_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en1,
  input  logic             en2,
  input  logic             en3,
`ifdef SIGMOID_TANH_EN
  input  logic             mode,
`endif
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  // AW: one guard bit so |most-negative| and 2x never wrap
  localparam int AW = WIDTH + 1;
  localparam int YW = FRAC + 1;
  localparam int OW = WIDTH + 2;

  localparam logic [AW-1:0] BRK_SAT  = AW'(brk_sat(FRAC));
  localparam logic [AW-1:0] BRK_LIN2 = AW'(brk_lin2(FRAC));
  localparam logic [AW-1:0] BRK_LIN1 = AW'(brk_lin1(FRAC));
  localparam logic [AW-1:0] OFS2_A   = AW'(ofs_lin2(FRAC));
  localparam logic [AW-1:0] OFS1_A   = AW'(ofs_lin1(FRAC));
  localparam logic [AW-1:0] OFS0_A   = AW'(ofs_lin0(FRAC));
  localparam logic [YW-1:0] ONE_Y    = YW'(one_fx(FRAC));
  localparam logic signed [OW-1:0] ONE_O = OW'(one_fx(FRAC));

  logic signed [AW-1:0] xe;
  logic [AW-1:0]        mag;
  seg_t                 seg;
  logic [YW-1:0]        ysum;
  logic signed [OW-1:0] ye, sv, rv;

  logic [AW-1:0]    a1_d, a1_q;
  logic             neg1_d, neg1_q;
  seg_t             seg1_d, seg1_q;
  logic [YW-1:0]    y2_d, y2_q;
  logic             neg2_d, neg2_q;
  logic [WIDTH-1:0] y3_d, y3_q;
`ifdef SIGMOID_TANH_EN
  logic             mode1_d, mode1_q;
  logic             mode2_d, mode2_q;
`endif

  // S1: magnitude with guard bit and segment classification
  always_comb begin
    xe = $signed({x[WIDTH-1], x});
`ifdef SIGMOID_TANH_EN
    if (mode) xe = $signed({x, 1'b0});
`endif
    mag = xe[AW-1] ? $unsigned(-xe) : $unsigned(xe);
    if (mag >= BRK_SAT)       seg = SEG_SAT;
    else if (mag >= BRK_LIN2) seg = SEG_LIN2;
    else if (mag >= BRK_LIN1) seg = SEG_LIN1;
    else                      seg = SEG_LIN0;
    a1_d   = en1 ? mag : a1_q;
    neg1_d = en1 ? xe[AW-1] : neg1_q;
    seg1_d = en1 ? seg : seg1_q;
`ifdef SIGMOID_TANH_EN
    mode1_d = en1 ? mode : mode1_q;
`endif
  end

  // S2: shift-add per segment; shifts truncate since a is non-negative
  always_comb begin
    ysum = ONE_Y;
    case (seg1_q)
      SEG_LIN0: ysum = YW'((a1_q >> 2) + OFS0_A);
      SEG_LIN1: ysum = YW'((a1_q >> 3) + OFS1_A);
      SEG_LIN2: ysum = YW'((a1_q >> 5) + OFS2_A);
      default:  ysum = ONE_Y;
    endcase
    y2_d   = en2 ? ysum : y2_q;
    neg2_d = en2 ? neg1_q : neg2_q;
`ifdef SIGMOID_TANH_EN
    mode2_d = en2 ? mode1_q : mode2_q;
`endif
  end

  // S3: reflect negatives about 0.5, clamp to [0, 1.0], optional tanh map
  always_comb begin
    ye = $signed(OW'(y2_q));
    sv = neg2_q ? ONE_O - ye : ye;
    if (sv < 0)          sv = '0;
    else if (sv > ONE_O) sv = ONE_O;
    rv = sv;
`ifdef SIGMOID_TANH_EN
    if (mode2_q) rv = (sv <<< 1) - ONE_O;
`endif
    y3_d = en3 ? WIDTH'(rv) : y3_q;
  end

  // Stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_q   <= '0;
      neg1_q <= 1'b0;
      seg1_q <= SEG_LIN0;
      y2_q   <= '0;
      neg2_q <= 1'b0;
      y3_q   <= '0;
`ifdef SIGMOID_TANH_EN
      mode1_q <= 1'b0;
      mode2_q <= 1'b0;
`endif
    end else begin
      a1_q   <= a1_d;
      neg1_q <= neg1_d;
      seg1_q <= seg1_d;
      y2_q   <= y2_d;
      neg2_q <= neg2_d;
      y3_q   <= y3_d;
`ifdef SIGMOID_TANH_EN
      mode1_q <= mode1_d;
      mode2_q <= mode2_d;
`endif
    end
  end

  assign y = y3_q;

endmodule

// File: rtl/sigmoid_stream.sv
// Streaming piecewise-linear sigmoid, LANES lanes sharing one valid/ready
// handshake, 3-stage elastic pipeline with bubble collapsing.
// Optional tanh mode port: define SIGMOID_TANH_EN.
module sigmoid_stream
  import sigmoid_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
`ifdef SIGMOID_TANH_EN
  input  logic                   mode,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data
);

  if (FRAC < 5 || WIDTH - FRAC < 4) begin : g_cfg_err
    $error("sigmoid_stream: need FRAC >= 5 and WIDTH-FRAC >= 4");
  end

  logic [STAGES:1] vld_d, vld_q, ld, en;

  // Shared control: a stage loads when empty or its successor moves on
  always_comb begin
    ld = '0;
    ld[STAGES] = ~vld_q[STAGES] | out_ready;
    for (int s = STAGES - 1; s >= 1; s--) ld[s] = ~vld_q[s] | ld[s+1];
    in_ready = ld[1] & ~rst;
    en = '0;
    en[1] = in_valid & in_ready;
    for (int s = 2; s <= STAGES; s++) en[s] = ld[s] & vld_q[s-1];
    vld_d = vld_q;
    if (ld[1]) vld_d[1] = en[1];
    for (int s = 2; s <= STAGES; s++) if (ld[s]) vld_d[s] = vld_q[s-1];
  end

  // Valid shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  assign out_valid = vld_q[STAGES];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sigmoid_lane #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en1  (en[1]),
      .en2  (en[2]),
      .en3  (en[3]),
`ifdef SIGMOID_TANH_EN
      .mode (mode),
`endif
      .x    (in_data[k*WIDTH +: WIDTH]),
      .y    (out_data[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_sigmoid_stream.sv
// Directed table + corner sequences + random backpressure for sigmoid_stream
// built with LANES=4 (default WIDTH/FRAC).
module tb_sigmoid_stream;
  localparam int W  = 16;
  localparam int L  = 4;
  localparam int DW = W * L;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
`ifdef SIGMOID_TANH_EN
  logic          mode;
`endif

  always #5 clk = ~clk;

  sigmoid_stream #(.WIDTH(W), .FRAC(12), .LANES(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef SIGMOID_TANH_EN
    .mode      (mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            chk_lat = 0;
  bit            prev_stall = 0;
  bit            s_acc = 0;
  bit            cur_mode = 0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] exp_q[$];
  int            cyc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Reference: piecewise sigmoid on an unbounded integer argument
  function automatic int sig_core(input int v);
    int a, yv;
    a = (v < 0) ? -v : v;
    if (a >= 20480)     yv = 4096;
    else if (a >= 9728) yv = a / 32 + 3456;
    else if (a >= 4096) yv = a / 8 + 2560;
    else                yv = a / 4 + 2048;
    return (v < 0) ? 4096 - yv : yv;
  endfunction

  function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input bit m);
    logic [DW-1:0] r;
    logic [W-1:0]  x;
    int            v;
    r = '0;
    for (int k = 0; k < L; k++) begin
      x = d[k*W +: W];
      v = int'($signed(x));
      if (m) r[k*W +: W] = 16'(2 * sig_core(2 * v) - 4096);
      else   r[k*W +: W] = 16'(sig_core(v));
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] r;
    logic [W-1:0]  v;
    r = '0;
    for (int k = 0; k < L; k++) begin
      v = 16'($urandom_range(0, 22000));
      if ($urandom_range(0, 1) == 1) v = -v;
      if ($urandom_range(0, 7) == 0) v = 16'($urandom);
      r[k*W +: W] = v;
    end
    return r;
  endfunction

  // One clock: drive at negedge, sample 1ns later, score what fires at the next edge
  task automatic cycle(input bit iv, input logic [DW-1:0] d, input logic [DW-1:0] e,
                       input bit ordy);
    logic [DW-1:0] ev;
    int            c;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
`ifdef SIGMOID_TANH_EN
    mode = cur_mode;
`endif
    #1;
    cyc++;
    if (prev_stall) begin
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_data", out_data, prev_data);
    end
    s_acc = in_valid && in_ready;
    if (s_acc) begin
      exp_q.push_back(e);
      cyc_q.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", out_data, '1 ^ out_data);
      end else begin
        ev = exp_q.pop_front();
        c  = cyc_q.pop_front();
        chk("out_data", out_data, ev);
        if (chk_lat) chk("latency", 64'(cyc - c), 64'(3));
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  endtask

  vec_t vecs[8];

  initial begin
    logic [DW-1:0] d;
    int            nacc;
    int            sent;

    vecs[0] = '{din: {4{16'h0000}}, dout: {4{16'h0800}}};
    vecs[1] = '{din: {4{16'h1000}}, dout: {4{16'h0C00}}};
    vecs[2] = '{din: {4{16'hF000}}, dout: {4{16'h0400}}};
    vecs[3] = '{din: {4{16'h5000}}, dout: {4{16'h1000}}};
    vecs[4] = '{din: {4{16'h8000}}, dout: {4{16'h0000}}};
    vecs[5] = '{din: {16'h5000, 16'hF000, 16'h1000, 16'h0000},
                dout: {16'h1000, 16'h0400, 16'h0C00, 16'h0800}};
    vecs[6] = '{din: {16'h0FFF, 16'h2600, 16'h25FF, 16'h4FFF},
                dout: {16'h0BFF, 16'h0EB0, 16'h0EBF, 16'h0FFF}};
    vecs[7] = '{din: {16'h7FFF, 16'hDA00, 16'hFFFF, 16'h8001},
                dout: {16'h1000, 16'h0150, 16'h0800, 16'h0000}};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef SIGMOID_TANH_EN
    mode = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", out_data, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'(1));

    // Directed table, back-to-back, out_ready held high
    chk_lat = 1;
    for (int i = 0; i < 8; i++) cycle(1, vecs[i].din, vecs[i].dout, 1);
    repeat (4) cycle(0, '0, '0, 1);
    chk_lat = 0;
    chk("table_drained", 64'(exp_q.size()), 64'(0));

    // Backpressure: fill with out_ready low, then resume
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      d = rand_beat();
      cycle(1, d, model(d, cur_mode), 0);
      if (s_acc) nacc++;
    end
    chk("bp_accepted", 64'(nacc), 64'(3));
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_out_valid", 64'(out_valid), 64'(1));
    for (int i = 0; i < 4; i++) begin
      d = rand_beat();
      cycle(1, d, model(d, cur_mode), 0);
    end
    for (int i = 0; i < 6; i++) begin
      d = rand_beat();
      cycle(1, d, model(d, cur_mode), 1);
      chk("resume_in_ready", 64'(in_ready), 64'(1));
      chk("resume_out_valid", 64'(out_valid), 64'(1));
    end
    repeat (4) cycle(0, '0, '0, 1);
    chk("bp_drained", 64'(exp_q.size()), 64'(0));

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) cycle(1, {4{16'h0000}}, {4{16'h0800}}, 0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    exp_q.delete();
    cyc_q.delete();
    prev_stall = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk_lat = 1;
    cycle(1, {4{16'h1000}}, {4{16'h0C00}}, 1);
    repeat (5) cycle(0, '0, '0, 1);
    chk_lat = 0;
    chk("post_rst_drained", 64'(exp_q.size()), 64'(0));

`ifdef SIGMOID_TANH_EN
    // tanh mode, then mode toggled every beat
    chk_lat = 1;
    cur_mode = 1;
    cycle(1, {16'h0000, 16'h0000, 16'hF000, 16'h1000},
             {16'h0000, 16'h0000, 16'hF400, 16'h0C00}, 1);
    for (int i = 0; i < 6; i++) begin
      cur_mode = (i % 2) == 1;
      cycle(1, {16'h5000, 16'h0000, 16'hF000, 16'h1000},
            cur_mode ? {16'h1000, 16'h0000, 16'hF400, 16'h0C00}
                     : {16'h1000, 16'h0800, 16'h0400, 16'h0C00}, 1);
    end
    cur_mode = 0;
    repeat (4) cycle(0, '0, '0, 1);
    chk_lat = 0;
    chk("tanh_drained", 64'(exp_q.size()), 64'(0));
`endif

    // Random stream with random backpressure
    sent = 0;
    for (int n = 0; n < 20000 && sent < 1000; n++) begin
      d = rand_beat();
`ifdef SIGMOID_TANH_EN
      cur_mode = $urandom_range(0, 1) == 1;
`endif
      cycle($urandom_range(0, 3) != 0, d, model(d, cur_mode), $urandom_range(0, 1) == 1);
      if (s_acc) sent++;
    end
    chk("rand_sent", 64'(sent), 64'(1000));
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) cycle(0, '0, '0, 1);
    chk("rand_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
